// File: rtl/mc_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_if
//   Connects the multicycle MIPS main controller to its datapath.
//   master : the controller. It takes opcode, zero and mem_ready, and it drives
//            every mux select, every write enable and the debug state.
//   slave  : the datapath. It sees the same signals with opposite directions.
// Signals
//   opcode[5:0]    instr[31:26] from IR
//   zero           ALU zero flag
//   mem_ready      memory done handshake
//   iord           mem addr mux: 0=PC, 1=ALUOut
//   mem_write      memory write strobe
//   ir_write       IR load
//   reg_dst        dest mux: 0=rt, 1=rd
//   mem_to_reg     writeback mux: 0=ALUOut, 1=MDR
//   reg_write      regfile write
//   alu_src_a      0=PC, 1=A
//   alu_src_b[1:0] 0=B, 1=4, 2=signext imm, 3=signext imm<<2
//   alu_op[1:0]    0=add, 1=sub, 2=funct-decoded
//   pc_src[1:0]    0=ALU result, 1=ALUOut, 2=jump target
//   pc_en          PC load
//   illegal_op     unknown-opcode pulse
//   state[3:0]     current controller state
// ----------------------------------------------------------------------------
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
//   Multicycle MIPS main controller. It walks FETCH -> DECODE -> execute steps
//   and drives the datapath mux selects and the state-element write enables.
//   The control outputs are registered: each clock edge loads decode(next state),
//   so the outputs always match the state that is current.
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mc_control_fsm_if.master (opcode/zero/mem_ready in, controls out)
// Build option
//   MC_CTRL_MEMWAIT_EN : when defined, FETCH, MEMRD and MEMWR stay in their
//                        state while mem_ready=0, and in FETCH the IR load and
//                        the PC load are gated by mem_ready. When undefined,
//                        mem_ready is ignored.
// ----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic             clk,
  input  logic             reset_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q, illegal_d;
  logic   store_q;   // MEMADR needs lw/sw after DECODE, and opcode is ignored then
  logic   mem_ok;    // the memory has finished its access this cycle

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // Control word for each state. Any field that a state does not name is 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'd1; end
      S_DECODE: c.alu_src_b = 2'd3;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
      S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.branch = 1'b1;
      end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP:   begin c.pc_src = 2'd2; c.pc_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic.
  // NOTE: every variable written in this block gets a default first, so no path
  // leaves a value to be held. Without those defaults synthesis infers latches.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;   // codes 13-15 are unreachable; recover to FETCH
    endcase
  end

  // NOTE: state is held in non-blocking assignments with an asynchronous reset.
  // When reset_n falls, the enables drop at once, without waiting for an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decode(state_d);
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) store_q <= (bus.opcode == OP_SW);
    end
  end

  // While FETCH waits on memory, the IR load and the PC increment are held off.
  // The JUMP and BRANCH PC loads are never gated.
  logic fetch_ok;
  assign fetch_ok = mem_ok | (state_q != S_FETCH);

  assign bus.iord       = ctrl_q.iord;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.ir_write   = ctrl_q.ir_write & fetch_ok;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.pc_src     = ctrl_q.pc_src;
  assign bus.pc_en      = (ctrl_q.pc_write & fetch_ok) | (ctrl_q.branch & bus.zero);
  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Directed bench for mc_control_fsm. It steps one clock at a time and compares
//   the state and the full control word with hand-computed values. The
//   mem_ready wait sequence runs only when MC_CTRL_MEMWAIT_EN is defined.
// ----------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word. The bit order matches ev() below.
  logic [14:0] ctl_obs;
  assign ctl_obs = {bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                    bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                    bus.alu_op, bus.pc_src, bus.pc_en, bus.illegal_op};

  function automatic logic [14:0] ev(
    input logic iord, mw, irw, rd, m2r, rw, asa,
    input logic [1:0] asb, aop, psrc,
    input logic pce, ill);
    return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pce, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then compare the state and the control word.
  task automatic step(input string tag, input logic [3:0] exp_state, input logic [14:0] exp_ctl);
    @(posedge clk);
    #1;
    check({tag, ".state"}, 32'(bus.state), 32'(exp_state));
    check({tag, ".ctl"}, 32'(ctl_obs), 32'(exp_ctl));
  endtask

  logic [14:0] c_zero, c_fetch, c_decode, c_memadr, c_memrd, c_memwb, c_memwr;
  logic [14:0] c_exec, c_aluwb, c_br_taken, c_br_not, c_addiwb, c_jump, c_fetch_ill;

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    c_zero      = ev(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0);
    c_fetch     = ev(0,0,1,0,0,0,0,2'd1,2'd0,2'd0,1,0);
    c_fetch_ill = ev(0,0,1,0,0,0,0,2'd1,2'd0,2'd0,1,1);
    c_decode    = ev(0,0,0,0,0,0,0,2'd3,2'd0,2'd0,0,0);
    c_memadr    = ev(0,0,0,0,0,0,1,2'd2,2'd0,2'd0,0,0);
    c_memrd     = ev(1,0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0);
    c_memwb     = ev(0,0,0,0,1,1,0,2'd0,2'd0,2'd0,0,0);
    c_memwr     = ev(1,1,0,0,0,0,0,2'd0,2'd0,2'd0,0,0);
    c_exec      = ev(0,0,0,0,0,0,1,2'd0,2'd2,2'd0,0,0);
    c_aluwb     = ev(0,0,0,1,0,1,0,2'd0,2'd0,2'd0,0,0);
    c_br_taken  = ev(0,0,0,0,0,0,1,2'd0,2'd1,2'd1,1,0);
    c_br_not    = ev(0,0,0,0,0,0,1,2'd0,2'd1,2'd1,0,0);
    c_addiwb    = ev(0,0,0,0,0,1,0,2'd0,2'd0,2'd0,0,0);
    c_jump      = ev(0,0,0,0,0,0,0,2'd0,2'd0,2'd2,1,0);

    // Reset held over two edges: IDLE, everything low.
    reset_n       = 1'b0;
    bus.opcode    = 6'b100011;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 32'(bus.state), 32'd0);
    check("reset.ctl", 32'(ctl_obs), 32'(c_zero));
    reset_n = 1'b1;

    // Release: IDLE -> FETCH, then the lw path 1,2,3,4,5,1.
    step("rel_fetch", 4'd1, c_fetch);
    step("lw_decode", 4'd2, c_decode);
    step("lw_memadr", 4'd3, c_memadr);
    step("lw_memrd",  4'd4, c_memrd);
    step("lw_memwb",  4'd5, c_memwb);
    step("lw_fetch",  4'd1, c_fetch);

    // beq: zero=1 takes the branch, zero=0 does not.
    bus.opcode = 6'b000100;
    step("beq_decode", 4'd2, c_decode);
    step("beq_branch_z0", 4'd9, c_br_not);
    bus.zero = 1'b1;
    #1;
    check("beq_taken.ctl", 32'(ctl_obs), 32'(c_br_taken));
    bus.zero = 1'b0;
    #1;
    check("beq_not_taken.ctl", 32'(ctl_obs), 32'(c_br_not));
    step("beq_fetch", 4'd1, c_fetch);

    // Illegal opcode: back to FETCH, illegal_op pulses for exactly one cycle.
    bus.opcode = 6'b111111;
    step("ill_decode", 4'd2, c_decode);
    step("ill_fetch",  4'd1, c_fetch_ill);
    step("ill_decode2", 4'd2, c_decode);

    // sw into MEMWR, then reset without a clock edge.
    bus.opcode = 6'b101011;
    step("sw_memadr", 4'd3, c_memadr);
    bus.opcode = 6'b100011;   // a changed opcode outside DECODE must not redirect
    step("sw_memwr", 4'd6, c_memwr);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.state", 32'(bus.state), 32'd0);
    check("async_rst.mem_write", 32'(bus.mem_write), 32'd0);
    check("async_rst.ctl", 32'(ctl_obs), 32'(c_zero));
    reset_n = 1'b1;
    step("rst2_fetch", 4'd1, c_fetch);

    // R-type.
    bus.opcode = 6'b000000;
    step("rt_decode", 4'd2, c_decode);
    step("rt_exec",   4'd7, c_exec);
    step("rt_aluwb",  4'd8, c_aluwb);
    step("rt_fetch",  4'd1, c_fetch);

    // addi.
    bus.opcode = 6'b001000;
    step("addi_decode", 4'd2, c_decode);
    step("addi_ex",     4'd10, c_memadr);
    step("addi_wb",     4'd11, c_addiwb);
    step("addi_fetch",  4'd1, c_fetch);

    // j.
    bus.opcode = 6'b000010;
    step("j_decode", 4'd2, c_decode);
    step("j_jump",   4'd12, c_jump);
    step("j_fetch",  4'd1, c_fetch);

`ifdef MC_CTRL_MEMWAIT_EN
    // sw with mem_ready low for three MEMWR cycles: MEMWR lasts four cycles.
    bus.opcode = 6'b101011;
    step("mw_decode", 4'd2, c_decode);
    step("mw_memadr", 4'd3, c_memadr);
    bus.mem_ready = 1'b0;
    step("mw_memwr1", 4'd6, c_memwr);
    step("mw_memwr2", 4'd6, c_memwr);
    step("mw_memwr3", 4'd6, c_memwr);
    step("mw_memwr4", 4'd6, c_memwr);
    bus.mem_ready = 1'b1;
    #1;
    check("mw_memwr4_ready.ctl", 32'(ctl_obs), 32'(c_memwr));
    step("mw_fetch", 4'd1, c_fetch);
    // FETCH stalls: IR load and PC load are gated off while mem_ready=0.
    bus.mem_ready = 1'b0;
    #1;
    check("mw_fetch_stall.ctl", 32'(ctl_obs),
          32'(ev(0,0,0,0,0,0,0,2'd1,2'd0,2'd0,0,0)));
    step("mw_fetch_hold", 4'd1, ev(0,0,0,0,0,0,0,2'd1,2'd0,2'd0,0,0));
    bus.mem_ready = 1'b1;
    #1;
    check("mw_fetch_go.ctl", 32'(ctl_obs), 32'(c_fetch));
    step("mw_decode2", 4'd2, c_decode);
`else
    // mem_ready is ignored: a low mem_ready still yields one-cycle states.
    bus.opcode    = 6'b101011;
    bus.mem_ready = 1'b0;
    #1;
    check("nw_fetch.ctl", 32'(ctl_obs), 32'(c_fetch));
    step("nw_decode", 4'd2, c_decode);
    step("nw_memadr", 4'd3, c_memadr);
    step("nw_memwr",  4'd6, c_memwr);
    step("nw_fetch",  4'd1, c_fetch);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
